// File: rtl/ddram_arbiter.sv
// DDRAM arbiter: three requesters share a single-beat Avalon-MM DDRAM port.
// The download write port has fixed top priority. The CPU and video read
// ports alternate round-robin. At most one command is in flight at a time.
//
// Ports
//   clk_sys, reset_n           clock, asynchronous active-low reset
//   wr_req/addr/data, wr_ack   download halfword write port (byte address)
//   cpu_req/addr, cpu_data/ack 68k read port (64-bit word offset)
//   vid_req/addr, vid_data/ack video read port (64-bit word offset)
//   ddram_*                    Avalon-MM master (busy = waitrequest)
//   err_timeout                sticky flag, a read was forcibly completed
module ddram_arbiter #(
  parameter logic [28:0] DDR_BASE    = 29'h0600000,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        wr_req,
  input  logic [26:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        cpu_req,
  input  logic [25:0] cpu_addr,
  output logic [63:0] cpu_data,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [25:0] vid_addr,
  output logic [63:0] vid_data,
  output logic        vid_ack,
  output logic [28:0] ddram_addr,
  output logic [7:0]  ddram_burstcnt,
  output logic        ddram_rd,
  output logic        ddram_we,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  input  logic        ddram_busy,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  output logic        err_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StWrIssue, StRdIssue, StRdWait, StDone} state_e;
  typedef enum logic [1:0] {GntWr, GntCpu, GntVid} gnt_e;

  state_e         state_q, state_d;
  gnt_e           gnt_q, gnt_sel;
  logic           any_req;
  logic           last_vid_q;   // 1: video was the last read port served
  logic [CntW-1:0] cnt_q;
  logic [28:0]    addr_q;
  logic [63:0]    din_q;
  logic [7:0]     be_q;
  logic [63:0]    cpu_data_q, vid_data_q;
  logic           err_q;
  logic           rd_done, rd_timeout;

  // Byte-address bit 0 has no meaning for a halfword write.
  logic unused_wr_addr0;
  assign unused_wr_addr0 = wr_addr[0];

  // Requester selection, only acted upon in StIdle.
  always_comb begin
    any_req = wr_req | cpu_req | vid_req;
    gnt_sel = GntWr;
    if (wr_req) begin
      gnt_sel = GntWr;
    end else if (cpu_req && (!vid_req || last_vid_q)) begin
      gnt_sel = GntCpu;
    end else if (vid_req) begin
      gnt_sel = GntVid;
    end
  end

  // Data return wins over a timeout landing on the same edge.
  assign rd_done    = (state_q == StRdWait) && ddram_dout_ready;
  assign rd_timeout = (state_q == StRdWait) && !ddram_dout_ready && (cnt_q == CntLast);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) state_d = (gnt_sel == GntWr) ? StWrIssue : StRdIssue;
      end
      StWrIssue: if (!ddram_busy) state_d = StDone;
      StRdIssue: if (!ddram_busy) state_d = StRdWait;
      StRdWait:  if (rd_done || rd_timeout) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; all are low while in reset.
  always_comb begin
    ddram_rd       = (state_q == StRdIssue);
    ddram_we       = (state_q == StWrIssue);
    wr_ack         = (state_q == StDone) && (gnt_q == GntWr);
    cpu_ack        = (state_q == StDone) && (gnt_q == GntCpu);
    vid_ack        = (state_q == StDone) && (gnt_q == GntVid);
    ddram_burstcnt = 8'd1;
    ddram_addr     = addr_q;
    ddram_din      = din_q;
    ddram_be       = be_q;
    cpu_data       = cpu_data_q;
    vid_data       = vid_data_q;
    err_timeout    = err_q;
  end

  // Grant latch and command datapath; held stable through the issue phase.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= GntWr;
      last_vid_q <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      be_q       <= '0;
    end else if (state_q == StIdle && any_req) begin
      gnt_q <= gnt_sel;
      unique case (gnt_sel)
        GntWr: begin
          addr_q <= DDR_BASE + {5'd0, wr_addr[26:3]};
          be_q   <= 8'b11 << {wr_addr[2:1], 1'b0};
          din_q  <= {4{wr_data}};
        end
        GntCpu: begin
          last_vid_q <= 1'b0;
          addr_q     <= DDR_BASE + {3'd0, cpu_addr};
          be_q       <= 8'hFF;
          din_q      <= '0;
        end
        GntVid: begin
          last_vid_q <= 1'b1;
          addr_q     <= DDR_BASE + {3'd0, vid_addr};
          be_q       <= 8'hFF;
          din_q      <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read wait timer: zero on entry to StRdWait, counts each waiting cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == StRdWait) begin
      cnt_q <= cnt_q + CntW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Returned data per port, and the sticky timeout flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_data_q <= '0;
      vid_data_q <= '0;
      err_q      <= 1'b0;
    end else if (rd_done || rd_timeout) begin
      if (gnt_q == GntCpu) cpu_data_q <= rd_done ? ddram_dout : 64'd0;
      if (gnt_q == GntVid) vid_data_q <= rd_done ? ddram_dout : 64'd0;
      if (rd_timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Self-checking bench for ddram_arbiter: directed scenarios plus random
// transactions, each compared against expectations derived from address
// arithmetic and cycle-count rules for the bus handshake.
module tb_ddram_arbiter;

  localparam logic [28:0] Base = 29'h0600000;
  localparam int          To   = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        wr_req, cpu_req, vid_req;
  logic [26:0] wr_addr;
  logic [15:0] wr_data;
  logic [25:0] cpu_addr, vid_addr;
  logic        wr_ack, cpu_ack, vid_ack;
  logic [63:0] cpu_data, vid_data;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt, ddram_be;
  logic        ddram_rd, ddram_we;
  logic [63:0] ddram_din, ddram_dout;
  logic        ddram_busy, ddram_dout_ready;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_cpu = '0;
  logic [63:0] exp_vid = '0;
  logic        exp_err = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ddram_arbiter #(.DDR_BASE(Base), .TIMEOUT_CYC(To)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt), .ddram_rd(ddram_rd),
    .ddram_we(ddram_we), .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_busy(ddram_busy), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Write with b busy cycles; expects we for b+1 cycles and ack b+2 edges after req.
  task automatic do_write(input logic [26:0] wa, input logic [15:0] wd, input int b,
                          input string tag);
    int n, m, wec, ackc, lat, bad, unstable, exp_lat, sh;
    logic [63:0] sum;
    logic [28:0] a0, exp_addr;
    logic [7:0]  be0, exp_be;
    logic [63:0] d0;
    n = 0; wec = 0; ackc = 0; lat = 0; bad = 0; unstable = 0;
    a0 = '0; be0 = '0; d0 = '0;
    exp_lat  = b + 2;
    sum      = 64'(Base) + 64'(wa / 8);
    exp_addr = sum[28:0];
    sh       = ((int'(wa) / 2) % 4) * 2;
    exp_be   = 8'(32'd3 << sh);
    wr_addr = wa; wr_data = wd; wr_req = 1'b1;
    while (n < exp_lat + 3) begin
      m = n + 1;
      ddram_busy = (m <= b + 1);
      ddram_dout_ready = 1'($urandom_range(1, 0));
      ddram_dout = {$urandom, $urandom};
      tick();
      n++;
      if (ddram_we) begin
        wec++;
        if (wec == 1) begin
          a0 = ddram_addr; be0 = ddram_be; d0 = ddram_din;
        end else if (ddram_addr !== a0 || ddram_be !== be0 || ddram_din !== d0) begin
          unstable++;
        end
      end
      if (ddram_rd || cpu_ack || vid_ack) bad++;
      if (wr_ack) begin
        ackc++; lat = n; wr_req = 1'b0;
      end
    end
    wr_req = 1'b0; ddram_busy = 1'b0; ddram_dout_ready = 1'b0;
    chk({tag, "_we_cycles"}, 64'(wec), 64'(b + 1));
    chk({tag, "_ack_count"}, 64'(ackc), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_addr"}, 64'(a0), 64'(exp_addr));
    chk({tag, "_be"}, 64'(be0), 64'(exp_be));
    chk({tag, "_din"}, d0, {wd, wd, wd, wd});
    chk({tag, "_stable"}, 64'(unstable), 64'd0);
    chk({tag, "_stray"}, 64'(bad), 64'd0);
    chk({tag, "_err"}, 64'(err_timeout), 64'(exp_err));
  endtask

  // Read with b busy cycles and data k edges after accept (k=0: never returned).
  task automatic do_read(input bit is_vid, input logic [25:0] ra, input int b, input int k,
                         input logic [63:0] dout, input string tag);
    int n, m, rdc, ackc, lat, bad, unstable, exp_lat, ret_edge;
    logic [63:0] sum;
    logic [28:0] a0;
    logic [7:0]  be0;
    n = 0; rdc = 0; ackc = 0; lat = 0; bad = 0; unstable = 0;
    a0 = '0; be0 = '0;
    exp_lat  = b + 2 + ((k == 0) ? To : k);
    ret_edge = (k == 0) ? -1 : b + 2 + k;
    sum = 64'(Base) + 64'(ra);
    if (is_vid) begin
      vid_addr = ra; vid_req = 1'b1;
    end else begin
      cpu_addr = ra; cpu_req = 1'b1;
    end
    while (n < exp_lat + 3) begin
      m = n + 1;
      ddram_busy = (m <= b + 1);
      // Spurious dout_ready outside the wait phase must be ignored.
      if (m <= b + 1 || m > exp_lat) ddram_dout_ready = 1'($urandom_range(1, 0));
      else ddram_dout_ready = (m == ret_edge);
      ddram_dout = (m == ret_edge) ? dout : {$urandom, $urandom};
      tick();
      n++;
      if (ddram_rd) begin
        rdc++;
        if (rdc == 1) begin
          a0 = ddram_addr; be0 = ddram_be;
        end else if (ddram_addr !== a0 || ddram_be !== be0) begin
          unstable++;
        end
      end
      if (ddram_we || wr_ack || (is_vid ? cpu_ack : vid_ack)) bad++;
      if (is_vid ? vid_ack : cpu_ack) begin
        ackc++; lat = n;
        if (is_vid) vid_req = 1'b0; else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0; ddram_busy = 1'b0; ddram_dout_ready = 1'b0;
    if (is_vid) exp_vid = (k == 0) ? 64'd0 : dout;
    else exp_cpu = (k == 0) ? 64'd0 : dout;
    if (k == 0) exp_err = 1'b1;
    chk({tag, "_rd_cycles"}, 64'(rdc), 64'(b + 1));
    chk({tag, "_ack_count"}, 64'(ackc), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_addr"}, 64'(a0), 64'(sum[28:0]));
    chk({tag, "_be"}, 64'(be0), 64'hFF);
    chk({tag, "_stable"}, 64'(unstable), 64'd0);
    chk({tag, "_stray"}, 64'(bad), 64'd0);
    chk({tag, "_cpu_data"}, cpu_data, exp_cpu);
    chk({tag, "_vid_data"}, vid_data, exp_vid);
    chk({tag, "_err"}, 64'(err_timeout), 64'(exp_err));
  endtask

  // Serves requests with an always-ready memory, recording ack order as hex digits
  // (1=wr, 2=cpu, 3=vid).
  task automatic race(input int cnt, input logic [63:0] d, output logic [11:0] ord);
    int got;
    got = 0; ord = '0;
    ddram_busy = 1'b0; ddram_dout_ready = 1'b1; ddram_dout = d;
    for (int i = 0; i < 40 && got < cnt; i++) begin
      tick();
      if (wr_ack)  begin ord = {ord[7:0], 4'h1}; wr_req = 1'b0;  got++; end
      if (cpu_ack) begin ord = {ord[7:0], 4'h2}; cpu_req = 1'b0; got++; exp_cpu = d; end
      if (vid_ack) begin ord = {ord[7:0], 4'h3}; vid_req = 1'b0; got++; exp_vid = d; end
    end
    wr_req = 1'b0; cpu_req = 1'b0; vid_req = 1'b0; ddram_dout_ready = 1'b0;
    tick();
  endtask

  initial begin
    logic [11:0] ord;
    int acks;
    reset_n = 1'b0;
    wr_req = 1'b1; cpu_req = 1'b1; vid_req = 1'b1;
    wr_addr = 27'h0000040; wr_data = 16'h1234;
    cpu_addr = 26'h0000100; vid_addr = 26'h0000200;
    ddram_busy = 1'b0; ddram_dout_ready = 1'b0; ddram_dout = '0;
    #3;
    chk("rst_rd", 64'(ddram_rd), 64'd0);
    chk("rst_we", 64'(ddram_we), 64'd0);
    chk("rst_acks", 64'({wr_ack, cpu_ack, vid_ack}), 64'd0);
    chk("rst_addr", 64'(ddram_addr), 64'd0);
    chk("rst_din", ddram_din, 64'd0);
    chk("rst_be", 64'(ddram_be), 64'd0);
    chk("rst_cpu_data", cpu_data, 64'd0);
    chk("rst_vid_data", vid_data, 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("burstcnt", 64'(ddram_burstcnt), 64'd1);

    // All three requesting at reset release: write first, then cpu, then vid.
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    race(3, 64'h5555AAAA5555AAAA, ord);
    chk("contend_order3", 64'(ord), 64'h123);
    cpu_req = 1'b1; vid_req = 1'b1;
    race(2, 64'h0F0F0F0F0F0F0F0F, ord);
    chk("contend_order2", 64'(ord[7:0]), 64'h23);
    chk("contend_cpu_data", cpu_data, exp_cpu);
    chk("contend_vid_data", vid_data, exp_vid);

    do_write(27'h0000006, 16'hBEEF, 0, "wr_beef");
    do_read(1'b0, 26'h0000010, 4, 2, 64'h0123456789ABCDEF, "rd_stall");

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(2, 0))
        0: do_write(27'($urandom), 16'($urandom), int'($urandom_range(3, 0)), "rnd_wr");
        1: do_read(1'b0, 26'($urandom), int'($urandom_range(3, 0)),
                   int'($urandom_range(To, 1)), {$urandom, $urandom}, "rnd_cpu");
        default: do_read(1'b1, 26'($urandom), int'($urandom_range(3, 0)),
                         int'($urandom_range(To, 1)), {$urandom, $urandom}, "rnd_vid");
      endcase
    end

    do_read(1'b1, 26'h0000123, 0, 0, 64'd0, "timeout");
    do_read(1'b0, 26'h3FFFFFF, 1, 3, 64'hCAFEF00DDEADBEEF, "after_to");
    do_write(27'h7FFFFFE, 16'hA55A, 2, "wr_top");

    // Reset while a video read is waiting for data.
    vid_addr = 26'h0000040; vid_req = 1'b1; ddram_busy = 1'b0;
    tick(); tick(); tick();
    vid_req = 1'b0;
    #2;
    reset_n = 1'b0;
    exp_cpu = '0; exp_vid = '0; exp_err = 1'b0;
    #1;
    chk("midrst_rd", 64'(ddram_rd), 64'd0);
    chk("midrst_acks", 64'({wr_ack, cpu_ack, vid_ack}), 64'd0);
    chk("midrst_err", 64'(err_timeout), 64'd0);
    chk("midrst_addr", 64'(ddram_addr), 64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    acks = 0;
    for (int i = 1; i <= 6; i++) begin
      ddram_dout_ready = (i == 2);
      ddram_dout = 64'hFFFF0000FFFF0000;
      tick();
      acks += int'(wr_ack) + int'(cpu_ack) + int'(vid_ack) + int'(ddram_rd) + int'(ddram_we);
    end
    ddram_dout_ready = 1'b0;
    chk("postrst_activity", 64'(acks), 64'd0);
    chk("postrst_cpu_data", cpu_data, 64'd0);
    chk("postrst_vid_data", vid_data, 64'd0);
    do_write(27'h0000002, 16'h00FF, 0, "postrst_wr");
    do_read(1'b1, 26'h0000001, 0, 1, 64'h1122334455667788, "postrst_vid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddram_arbiter.md
DDRAM_ARBITER -- requirements
Module: ddram_arbiter

Interface
REQ-001 SHALL have parameter DDR_BASE, default 29'h0600000, meaning 64-bit word base added to every DDRAM address.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, meaning max cycles in RD_WAIT before forced completion.
REQ-003 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 wr_req  in  1  download write request, level, held until wr_ack.
REQ-006 wr_addr  in  27  download byte address, bit 0 ignored.
REQ-007 wr_data  in  16  download halfword, [7:0] at lower byte address.
REQ-008 wr_ack  out  1  one-cycle pulse, write accepted by DDRAM.
REQ-009 cpu_req / cpu_addr[25:0] / cpu_data[63:0] / cpu_ack  in/in/out/out  68k read port: level request, word offset, returned data, one-cycle completion pulse.
REQ-010 vid_req / vid_addr[25:0] / vid_data[63:0] / vid_ack  in/in/out/out  video read port, same semantics as cpu port.
REQ-011 ddram_addr  out  29;  ddram_burstcnt  out  8, constant 1;  ddram_rd, ddram_we  out  1;  ddram_din  out  64;  ddram_be  out  8.
REQ-012 ddram_busy  in  1;  ddram_dout  in  64;  ddram_dout_ready  in  1  (Avalon-MM waitrequest semantics).
REQ-013 err_timeout  out  1  sticky read-timeout flag.

Function
REQ-014 SHALL implement states IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE.
REQ-015 In IDLE, arbitration SHALL be: wr_req highest; between cpu_req and vid_req round-robin on a last-served bit (reset value = vid served, so cpu wins first tie).
REQ-016 Grant SHALL latch requester ID and address; transition IDLE->WR_ISSUE or RD_ISSUE on the next edge; no preemption once granted.
REQ-017 ddram_rd/ddram_we SHALL assert in first ISSUE cycle and hold with stable addr/din/be until an edge where ddram_busy=0; command accepted at that edge.
REQ-018 Write accept: WR_ISSUE->DONE, wr_ack=1 for that DONE cycle only; ddram_we=0 in DONE.
REQ-019 Read accept: RD_ISSUE->RD_WAIT, ddram_rd=0; on edge with ddram_dout_ready=1, register ddram_dout into granted port's *_data and go DONE with that port's *_ack=1 one cycle.
REQ-020 *_data SHALL hold last returned value until next completion for that port.
REQ-021 DONE->IDLE unconditionally; requester SHALL have dropped req by the IDLE cycle, else it is treated as a new request.
REQ-022 Write mapping: ddram_addr = DDR_BASE + wr_addr[26:3]; ddram_be = 8'b11 << (2*wr_addr[2:1]); ddram_din = {4{wr_data}}.
REQ-023 Read mapping: ddram_addr = DDR_BASE + zero-extended 26-bit offset; ddram_be = 8'hFF; addition modulo 2^29.
REQ-024 Timeout counter SHALL clear on RD_WAIT entry; at TIMEOUT_CYC cycles without dout_ready: go DONE, ack granted port, *_data = 0, set err_timeout.
REQ-025 ddram_dout_ready outside RD_WAIT SHALL be ignored.
REQ-026 Minimum latency, busy=0, dout_ready k cycles after accept: write req->ack 3 cycles; read req->ack 3+k cycles.
REQ-027 At most one DDRAM command outstanding at any time.

Reset
REQ-028 On reset_n=0, immediately: state IDLE, ddram_rd=ddram_we=0, all acks 0, *_data=0, ddram_addr/din/be=0, err_timeout=0, timeout counter 0, last-served = vid.
REQ-029 Reset mid-operation SHALL abandon the transaction without ack; a late dout_ready after release SHALL be ignored per REQ-025.

Verification
REQ-030 Write: wr_addr=27'h000006, wr_data=16'hBEEF, busy=0 -> ddram_addr=29'h0600000, be=8'hC0, din=64'hBEEFBEEFBEEFBEEF, wr_ack 3 cycles after req.
REQ-031 Read with busy stall: cpu_addr=26'h0000010, busy=1 for 4 cycles, dout_ready 2 cycles after accept with 64'h0123456789ABCDEF -> rd held 5 cycles, addr 29'h0600010, cpu_data matches, single cpu_ack.
REQ-032 Contention: cpu_req, vid_req, wr_req all high at reset release -> service order wr, cpu, vid; then cpu+vid re-requested -> cpu, vid.
REQ-033 Timeout (TIMEOUT_CYC=8): vid read, dout_ready never -> vid_ack after 8 RD_WAIT cycles, vid_data=0, err_timeout=1 until reset.
REQ-034 Reset in RD_WAIT, dout_ready pulsed 2 cycles after release -> no ack, *_data unchanged at 0, state IDLE.
